cla_nibble_seq: RTL

Nibble-serial 16-bit adder sequencer that wraps the team's registered 4-bit `cla` stage. It accepts two 16-bit operands and a carry-in through a valid/ready handshake. It feeds the `cla` one nibble pair per step, LSB nibble first, with the carry chained from each step's `C4` to the next step's `Cin`. It then presents the assembled 16-bit sum, carry-out and signed overflow through a second valid/ready handshake. The block sits directly upstream and downstream of `cla`: it drives `cla` operands and consumes `cla` results.

---
 rtl/cla_nibble_seq.sv | 81 ++++++++
 1 files changed

// File: rtl/cla_nibble_seq.sv
// cla_nibble_seq: nibble-serial 16-bit adder that sequences a registered 4-bit cla stage,
// LSB nibble first with the carry chained between steps, behind valid/ready handshakes.
module cla_nibble_seq #(
    parameter int CLA_LAT = 1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    input  logic        op_cin,
    output logic [3:0]  cla_a,
    output logic [3:0]  cla_b,
    output logic        cla_cin,
    input  logic [3:0]  cla_s,
    input  logic        cla_c4,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] sum,
    output logic        cout,
    output logic        ovf
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t      state;
    logic [15:0] a_r, b_r, sum_r;
    logic        carry_r, cout_r, ovf_r;
    logic [1:0]  idx;
    logic        wcnt;
    logic        capture;
    assign capture   = wcnt == 1'(CLA_LAT);
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign cla_a     = state == CALC ? a_r[{idx, 2'b00} +: 4] : 4'd0;
    assign cla_b     = state == CALC ? b_r[{idx, 2'b00} +: 4] : 4'd0;
    assign cla_cin   = state == CALC ? carry_r : 1'b0;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state   <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            idx     <= '0;
            wcnt    <= 1'b0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r     <= op_a;
                    b_r     <= op_b;
                    carry_r <= op_cin;
                    idx     <= '0;
                    wcnt    <= 1'b0;
                    sum_r   <= '0;
                    state   <= CALC;
                end
                CALC: if (capture) begin
                    sum_r[{idx, 2'b00} +: 4] <= cla_s;
                    carry_r <= cla_c4;
                    wcnt    <= 1'b0;
                    idx     <= idx + 2'd1;
                    // last nibble: sign bits of the top nibble decide overflow
                    if (idx == 2'd3) begin
                        cout_r <= cla_c4;
                        ovf_r  <= (a_r[15] == b_r[15]) && (cla_s[3] != a_r[15]);
                        state  <= DONE;
                    end
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
